// File: rtl/branch_pht.sv
// Pattern history table of saturating counters with one-cycle lookup.
// Optional gshare indexing and global history under `PHT_GSHARE_EN.
module branch_pht #(
  parameter int IDX_W  = 10,
  parameter int CNT_W  = 3,
  parameter int HIST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_addr,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic [31:0]       upd_inst,
  output logic              ready,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] ghr
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] INIT_VAL =
    CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             lk_acc;
  logic             up_ok;
  logic [CNT_W-1:0] up_old;
  logic [CNT_W-1:0] up_new;
  logic             unused_inst;

  assign unused_inst = ^upd_inst[31:7];
  assign ready  = (state == S_RUN);
  assign lk_acc = lookup_valid & ready & ~flush;
  assign up_ok  = upd_valid & ready & ~flush
                & (upd_inst[6:0] == 7'b1100011);
  assign up_old = mem[upd_idx];

  always_comb begin
    up_new = up_old;
    if (upd_taken) begin
      if (up_old != CNT_MAX) up_new = up_old + 1'b1;
    end else begin
      if (up_old != '0) up_new = up_old - 1'b1;
    end
  end

`ifdef PHT_GSHARE_EN
  logic [HIST_W-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (flush) begin
      hist <= '0;
    end else if (up_ok) begin
      hist <= (hist << 1) | HIST_W'(upd_taken);
    end
  end

  assign ghr = hist;
  assign idx = lookup_addr ^ IDX_W'(hist);
`else
  assign ghr = '0;
  assign idx = lookup_addr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      ptr   <= '0;
    end else if (flush) begin
      state <= S_INIT;
      ptr   <= '0;
    end else if (state == S_INIT) begin
      ptr <= ptr + 1'b1;
      if (&ptr) state <= S_RUN;
    end
  end

  // Counters carry no reset; the sweep defines them.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (state == S_INIT) begin
        mem[ptr] <= INIT_VAL;
      end else if (up_ok) begin
        mem[upd_idx] <= up_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= lk_acc;
      if (lk_acc) begin
        pred_idx <= idx;
        // Same-cycle update to this entry is forwarded.
        if (up_ok && upd_idx == idx) begin
          pred_taken <= up_new[CNT_W-1];
        end else begin
          pred_taken <= mem[idx][CNT_W-1];
        end
      end
    end
  end

endmodule

// File: doc/branch_pht.md
BRANCH_PHT -- requirements
Module: branch_pht

Interface
REQ-001 Parameter IDX_W, default 10, sets table index width; the table holds 2^IDX_W entries.
REQ-002 Parameter CNT_W, default 3, sets counter width per entry; legal range 2..4.
REQ-003 Parameter HIST_W, default 8, sets global history width; legal range 1..IDX_W.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  one-cycle pulse; restarts table initialisation.
REQ-007 lookup_valid  in  1  lookup request this cycle.
REQ-008 lookup_addr  in  IDX_W  branch address bits for lookup.
REQ-009 upd_valid  in  1  branch resolution present this cycle.
REQ-010 upd_idx  in  IDX_W  table index returned with the original prediction.
REQ-011 upd_taken  in  1  resolved outcome, 1 = taken.
REQ-012 upd_inst  in  32  resolved instruction word.
REQ-013 ready  out  1  table initialised; lookups and updates accepted.
REQ-014 pred_valid  out  1  pred_taken and pred_idx are valid.
REQ-015 pred_taken  out  1  prediction, 1 = taken.
REQ-016 pred_idx  out  IDX_W  table index used for this prediction.
REQ-017 ghr  out  HIST_W  current global history register.

Function
REQ-018 FSM states: INIT (sweep table), RUN (normal); ready = 1 only in RUN.
REQ-019 INIT writes INIT_VAL = 2^(CNT_W-1)-1 (weakly not-taken) to one entry per cycle, index 0 up to 2^IDX_W-1, then enters RUN next cycle.
REQ-020 INIT sweep takes exactly 2^IDX_W cycles; ready rises on the cycle after the last entry write.
REQ-021 flush in any state clears ghr to 0, resets the sweep pointer to 0, and enters INIT; flush during INIT restarts the sweep from 0.
REQ-022 In INIT, lookups are ignored (pred_valid = 0) and updates are dropped (no counter or ghr change).
REQ-023 Lookup index idx = lookup_addr XOR zero-extended ghr (see REQ-034).
REQ-024 Lookup latency one cycle: lookup accepted in cycle N gives pred_valid = 1 in N+1, with pred_idx = idx and pred_taken = MSB of counter[idx]; pred_valid = 0 in N+1 if no lookup in N.
REQ-025 Qualified update: upd_valid = 1, ready = 1, upd_inst[6:0] = 7'b1100011; all other updates are ignored.
REQ-026 Qualified taken: counter[upd_idx] increments, saturating at 2^CNT_W-1; qualified not-taken: decrements, saturating at 0.
REQ-027 Qualified update shifts ghr left one bit, inserting upd_taken at bit 0; the oldest bit is discarded.
REQ-028 Lookup and qualified update to the same index in the same cycle: the prediction reflects the post-update counter value (write-first bypass).
REQ-029 Lookup index uses ghr before any same-cycle history shift.
REQ-030 flush and qualified update in the same cycle: flush wins; the update is dropped.

Reset
REQ-031 rst_n low asynchronously forces state INIT, sweep pointer 0, ghr 0, pred_valid 0, pred_taken 0, pred_idx 0, ready 0.
REQ-032 Counter array has no reset; it is defined only after the INIT sweep completes.
REQ-033 Reset asserted mid-sweep or mid-RUN aborts all activity; a full sweep follows reset release.

Configuration
REQ-034 With macro PHT_GSHARE_EN defined: indexing per REQ-023 and ghr updates per REQ-027.
REQ-035 Without PHT_GSHARE_EN: idx = lookup_addr, ghr is held at 0, and no history register is built.

Verification (IDX_W=4, CNT_W=3, HIST_W=4, PHT_GSHARE_EN defined unless stated)
REQ-036 Release rst_n -> ready = 0 for 16 cycles, then 1; every first lookup in RUN -> pred_taken = 0 (counter 3).
REQ-037 Two qualified taken updates to idx 5, then lookup giving idx 5 -> counter 5, pred_taken = 1; 10 further taken updates -> counter saturates at 7.
REQ-038 upd_inst[6:0] = 7'b0110011 with upd_valid = 1 -> no counter change and ghr unchanged.
REQ-039 ghr = 4'b0000, updates taken, taken, not-taken -> ghr = 4'b0110; lookup_addr 4'b0011 -> pred_idx = 4'b0101.
REQ-040 Counter[2] = 4, not-taken update to idx 2 in the same cycle as a lookup giving idx 2 -> pred_taken = 0 next cycle (counter 3).
REQ-041 flush at sweep entry 9 -> sweep restarts at 0 and ready rises 16 cycles after flush; without PHT_GSHARE_EN, lookup_addr 4'b1010 -> pred_idx = 4'b1010.
